fetch_stage: RTL and testbench

//   Instruction-fetch stage directly downstream of the PC-select mux. Owns the

---
 rtl/fetch_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage that sits directly after the PC-select mux. It owns
// the architectural fetch PC, keeps at most one instruction-memory read in
// flight, and hands the returned instruction and its address to decode through
// the IF/ID pipeline register using a valid/ready handshake. A one-entry skid
// buffer catches a response that returns while decode is stalled. A jump
// redirect from EX/WB squashes everything fetched but not yet consumed.
//
// Ports
//   clk           in   1   clock, all state updates on the rising edge
//   reset         in   1   asynchronous, active-low reset
//   jumpIns_EXWB  in   1   redirect request from EX/WB (highest priority)
//   PCnew_EXWB    in   AW  redirect target PC
//   imem_req      out  1   read request to instruction memory (FETCH only)
//   imem_addr     out  AW  read address, always the current PC
//   imem_ready    in   1   memory accepts the request this cycle
//   imem_rvalid   in   1   read data valid, at least one cycle after accept
//   imem_rdata    in   IW  read data
//   valid_IFID    out  1   IF/ID register holds a valid instruction
//   instr_IFID    out  IW  fetched instruction
//   PC_IFID       out  AW  address the instruction was fetched from
//   ready_ID      in   1   decode consumes IF/ID this cycle if valid_IFID
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned   AW       = 8,
    parameter int unsigned   IW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          jumpIns_EXWB,
    input  logic [AW-1:0] PCnew_EXWB,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic          imem_rvalid,
    input  logic [IW-1:0] imem_rdata,
    output logic          valid_IFID,
    output logic [IW-1:0] instr_IFID,
    output logic [AW-1:0] PC_IFID,
    input  logic          ready_ID
);

    // FETCH : request issued, waiting for the memory to accept it
    // WAIT  : request accepted, waiting for its response
    // HOLD  : response parked in the skid buffer, decode is stalled
    // DRAIN : a squashed request is still outstanding; swallow its response
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t          r_state;
    logic [AW-1:0]   r_pc;          // next address to request
    logic [AW-1:0]   r_fetch_addr;  // address of the request in flight

    logic            r_valid;       // IF/ID register
    logic [IW-1:0]   r_instr;
    logic [AW-1:0]   r_pc_ifid;

    logic [IW-1:0]   r_skid_instr;  // skid entry; occupied exactly while in HOLD
    logic [AW-1:0]   r_skid_pc;

    // -------------------------------------------------------------------------
    // Next-state and event strobes
    // -------------------------------------------------------------------------
    state_t          w_state_nxt;
    logic            w_req;         // request presented to memory
    logic            w_accept;      // request accepted and not cancelled
    logic            w_load_mem;    // response goes straight into IF/ID
    logic            w_park;        // response goes into the skid buffer
    logic            w_load_skid;   // skid entry moves into IF/ID
    logic            w_load;        // IF/ID is written with new data
    logic            w_consume;     // decode takes IF/ID, nothing replaces it

    // NOTE: every signal driven here gets a default before the case statement;
    // a path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_accept    = 1'b0;
        w_load_mem  = 1'b0;
        w_park      = 1'b0;
        w_load_skid = 1'b0;

        unique case (r_state)
            S_FETCH: begin
                // The request is still visible during a redirect, but the
                // stage ignores the acceptance so the PC is not advanced.
                w_req = 1'b1;
                if (!jumpIns_EXWB && imem_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (jumpIns_EXWB) begin
                    // A response arriving together with the redirect is the
                    // one we were waiting for: drop it and refetch at once.
                    // Otherwise it is still coming and must be swallowed.
                    w_state_nxt = imem_rvalid ? S_FETCH : S_DRAIN;
                end else if (imem_rvalid) begin
                    if (!r_valid || ready_ID) begin
                        w_load_mem  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_park      = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // IF/ID is always valid here, so ready_ID alone means the
                // current entry leaves and the skid entry can replace it.
                if (jumpIns_EXWB) begin
                    w_state_nxt = S_FETCH;
                end else if (ready_ID) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end

            S_DRAIN: begin
                // A redirect here changes only the PC; the squashed response
                // still has to be discarded before a new request may go out.
                if (imem_rvalid) begin
                    w_state_nxt = S_FETCH;
                end
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    assign w_load    = w_load_mem | w_load_skid;
    assign w_consume = r_valid & ready_ID & ~w_load;

    // -------------------------------------------------------------------------
    // FSM state, PC and in-flight address
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values from before the edge, independent of order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_fetch_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (jumpIns_EXWB) begin
                r_pc <= PCnew_EXWB;
            end else if (w_accept) begin
                r_fetch_addr <= r_pc;
                r_pc         <= r_pc + AW'(1);  // wraps modulo 2^AW
            end
        end
    end

    // -------------------------------------------------------------------------
    // IF/ID pipeline register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_pc_ifid <= '0;
        end else if (jumpIns_EXWB) begin
            // Squash: the payload is left as is, only the valid bit matters.
            r_valid <= 1'b0;
        end else if (w_load_mem) begin
            r_valid   <= 1'b1;
            r_instr   <= imem_rdata;
            r_pc_ifid <= r_fetch_addr;
        end else if (w_load_skid) begin
            r_valid   <= 1'b1;
            r_instr   <= r_skid_instr;
            r_pc_ifid <= r_skid_pc;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Skid buffer
    // -------------------------------------------------------------------------
    // Occupancy is implied by the HOLD state, so only the payload is stored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (jumpIns_EXWB) begin
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (w_park) begin
            r_skid_instr <= imem_rdata;
            r_skid_pc    <= r_fetch_addr;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign valid_IFID = r_valid;
    assign instr_IFID = r_instr;
    assign PC_IFID    = r_pc_ifid;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Bench for fetch_stage. A behavioural instruction memory (in-order, variable
// latency, random back-pressure) answers every accepted request with
// addr ^ 16'hA500. The reference model describes the stage at stream level:
// decode must see consecutive PCs (mod 256) starting from RESET_PC after a
// reset or from the target after a redirect, each with its memory word. The
// stimulus side keeps that expected stream in a queue; an independent monitor
// pops one entry per handshake and compares.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int unsigned AW       = 8;
    localparam int unsigned IW       = 16;
    localparam logic [7:0]  RESET_PC = 8'h00;

    logic          clk = 1'b0;
    logic          reset;
    logic          jumpIns_EXWB;
    logic [AW-1:0] PCnew_EXWB;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          valid_IFID;
    logic [IW-1:0] instr_IFID;
    logic [AW-1:0] PC_IFID;
    logic          ready_ID;

    fetch_stage #(
        .AW       (AW),
        .IW       (IW),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .jumpIns_EXWB (jumpIns_EXWB),
        .PCnew_EXWB   (PCnew_EXWB),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .valid_IFID   (valid_IFID),
        .instr_IFID   (instr_IFID),
        .PC_IFID      (PC_IFID),
        .ready_ID     (ready_ID)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cycle);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [7:0] addr);
        return {8'h00, addr} ^ 16'hA500;
    endfunction

    // -------------------------------------------------------------------------
    // Reference model: expected instruction stream
    // -------------------------------------------------------------------------
    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_pc;

    // Restart the stream (reset or redirect).
    task automatic flush(input logic [7:0] start);
        exp_q.delete();
        model_pc = start;
    endtask

    // Keep a few upcoming instructions queued; runs after any flush of the
    // same cycle and before the next monitor sample.
    always @(posedge clk) begin
        #2;
        while (exp_q.size() < 4) begin
            exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            model_pc = model_pc + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Instruction memory: in-order responses, latency lat_min..lat_max
    // -------------------------------------------------------------------------
    typedef struct {
        logic [7:0] addr;
        int         rem;
    } pend_t;

    pend_t pend[$];
    int    lat_min    = 1;
    int    lat_max    = 1;
    bit    rand_ready = 1'b0;

    // Everything decided here is stable for the following rising edge.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        if (!reset) begin
            pend.delete();
        end else begin
            foreach (pend[i]) pend[i].rem--;
            if (pend.size() > 0 && pend[0].rem <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end
        end
        imem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (reset && imem_req && imem_ready && !jumpIns_EXWB) begin
            automatic int lat = $urandom_range(lat_min, lat_max);
            if (pend.size() > 0 && lat <= pend[pend.size()-1].rem)
                lat = pend[pend.size()-1].rem + 1;
            pend.push_back('{addr: imem_addr, rem: lat});
        end
    end

    // -------------------------------------------------------------------------
    // Monitor: one handshake per rising edge at most
    // -------------------------------------------------------------------------
    int         hs_count = 0;
    logic [7:0] hs_pc[$];
    int         hs_cyc[$];

    always @(negedge clk) begin
        if (reset === 1'b1 && valid_IFID && ready_ID) begin
            hs_count++;
            hs_pc.push_back(PC_IFID);
            hs_cyc.push_back(cycle);
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                automatic exp_t e = exp_q.pop_front();
                check("sb_pc", 32'(PC_IFID), 32'(e.pc));
                check("sb_instr", 32'(instr_IFID), 32'(e.instr));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver helpers (all entered and left at posedge + 1)
    // -------------------------------------------------------------------------
    task automatic redirect(input logic [7:0] target);
        jumpIns_EXWB = 1'b1;
        PCnew_EXWB   = target;
        @(posedge clk);
        #1;
        jumpIns_EXWB = 1'b0;
        PCnew_EXWB   = 8'($urandom);
        flush(target);
    endtask

    task automatic do_reset(input string name);
        #2;
        reset = 1'b0;
        #1;
        check({name, "_valid"}, 32'(valid_IFID), 32'd0);
        check({name, "_pc"}, 32'(imem_addr), 32'(RESET_PC));
        check({name, "_req"}, 32'(imem_req), 32'd1);
        flush(RESET_PC);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        for (int i = 0; i < budget && hs_count < target; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, 32'(hs_count >= target), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int base;
        int ok;

        reset        = 1'b0;
        jumpIns_EXWB = 1'b0;
        PCnew_EXWB   = 8'h00;
        ready_ID     = 1'b0;
        flush(RESET_PC);

        // Reset state
        idle(3);
        check("rst_valid", 32'(valid_IFID), 32'd0);
        check("rst_instr", 32'(instr_IFID), 32'd0);
        check("rst_pcifid", 32'(PC_IFID), 32'd0);
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_addr", 32'(imem_addr), 32'(RESET_PC));

        // 1: first instruction two edges after release, then one per 2 cycles
        ready_ID = 1'b1;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lat_edge1_valid", 32'(valid_IFID), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_edge2_valid", 32'(valid_IFID), 32'd1);
        check("lat_edge2_pc", 32'(PC_IFID), 32'(RESET_PC));
        check("lat_edge2_instr", 32'(instr_IFID), 32'h0000A500);
        @(posedge clk);
        #1;
        base = hs_count;
        wait_hs(base + 5, 40, "t1_progress");
        check("t1_throughput", 32'(hs_cyc[base + 4] - hs_cyc[base + 3]), 32'd2);

        // 2: decode stalls, second instruction parks in the skid buffer
        ready_ID = 1'b0;
        idle(6);
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_valid", 32'(valid_IFID), 32'd1);
        base     = hs_count;
        ready_ID = 1'b1;
        wait_hs(base + 3, 20, "t2_resume");

        // 3: redirect while the response is still outstanding
        lat_min = 3;
        lat_max = 3;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            if (pend.size() > 0 && pend[0].rem >= 2) ok = 1;
            else idle(1);
        end
        check("t3_reach_wait", 32'(ok), 32'd1);
        redirect(8'h40);
        check("t3_valid", 32'(valid_IFID), 32'd0);
        check("t3_drain_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 10 && !imem_req; i++) idle(1);
        check("t3_addr", 32'(imem_addr), 32'h40);
        base = hs_count;
        wait_hs(base + 1, 20, "t3_progress");
        check("t3_first_pc", 32'(hs_pc[base]), 32'h40);

        // 4: redirect in the same cycle as the response
        lat_min = 1;
        lat_max = 1;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            if (pend.size() > 0 && pend[0].rem == 1) ok = 1;
            else idle(1);
        end
        check("t4_reach_wait", 32'(ok), 32'd1);
        redirect(8'h10);
        check("t4_valid", 32'(valid_IFID), 32'd0);
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_addr", 32'(imem_addr), 32'h10);
        base = hs_count;
        wait_hs(base + 1, 20, "t4_progress");
        check("t4_first_pc", 32'(hs_pc[base]), 32'h10);

        // 5: PC wraps from FF to 00
        redirect(8'hFE);
        base = hs_count;
        wait_hs(base + 3, 30, "t5_progress");
        check("t5_pc0", 32'(hs_pc[base]), 32'hFE);
        check("t5_pc1", 32'(hs_pc[base + 1]), 32'hFF);
        check("t5_pc2", 32'(hs_pc[base + 2]), 32'h00);

        // 6: asynchronous reset while in HOLD
        ready_ID = 1'b0;
        idle(8);
        check("t6_in_hold", 32'(imem_req), 32'd0);
        do_reset("t6_rst");
        ready_ID = 1'b1;
        base = hs_count;
        wait_hs(base + 1, 20, "t6_progress");
        check("t6_first_pc", 32'(hs_pc[base]), 32'(RESET_PC));

        // Random phase: back-pressure, variable latency, redirects, resets
        lat_min    = 1;
        lat_max    = 3;
        rand_ready = 1'b1;
        base       = hs_count;
        for (int i = 0; i < 2500; i++) begin
            ready_ID = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                redirect(8'($urandom));
            end else if ($urandom_range(0, 399) == 0) begin
                do_reset("rnd_rst");
            end else begin
                idle(1);
            end
        end
        check("rnd_progress", 32'(hs_count - base > 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
